regmap0_bus_master: RTL and testbench
=====================================

// Module: regmap0_bus_master
// PURPOSE
//  Initiator for the simple register-bank bus: address, writeEnable, writeData,
//  readEnable and readData.
//  - Accepts one read or write command at a time on a valid/ready command port.
//  - Issues it to the register bank as a single-cycle enable pulse.
//  - Returns a response with read data (writes get an ack) on a valid/ready
//    response port.
//  - Sits between a CPU/host bridge or test sequencer and the regmap0 register bank.
// PARAMETERS
//  width         8  data width of the register bus and the cmd/rsp data fields
//  addressWidth  8  address width of the register bus
// PORTS
//  clk          in   1             clock
//  rstn         in   1             asynchronous reset, active-low
//  cmd_valid    in   1             command present
//  cmd_ready    out  1             command accepted when cmd_valid&cmd_ready
//  cmd_write    in   1             1=write, 0=read
//  cmd_addr     in   addressWidth  register address
//  cmd_wdata    in   width         write data (ignored for reads)
//  rsp_valid    out  1             response present
//  rsp_ready    in   1             response consumed when rsp_valid&rsp_ready
//  rsp_write    out  1             response belongs to a write (ack)
//  rsp_rdata    out  width         read data; 0 for write acks
//  address      out  addressWidth  register-bank address
//  writeEnable  out  1             register-bank write strobe
//  writeData    out  width         register-bank write data
//  readEnable   out  1             register-bank read strobe
//  readData     in   width         register-bank read data, registered one cycle after readEnable
// BEHAVIOUR
//  - All outputs are registered except cmd_ready, which decodes the state register
//    (1 only in IDLE).
//  - Reset (rstn=0, async):
//    - state=IDLE; cmd_ready=1.
//    - rsp_valid, rsp_write, rsp_rdata = 0.
//    - address, writeData = 0; writeEnable, readEnable = 0.
//    - A reset mid-transaction discards the transaction; no response is produced.
//  - FSM: IDLE -> ISSUE -> (RDWAIT, reads only) -> RESP -> IDLE.
//  - IDLE:
//    - On cmd_valid=1, latch cmd_write/cmd_addr/cmd_wdata into address/writeData.
//    - Drive writeEnable=cmd_write or readEnable=!cmd_write for the next cycle.
//    - Go to ISSUE.
//  - ISSUE (exactly 1 cycle):
//    - Exactly one strobe is high.
//    - Write: next state is RESP with rsp_write=1, rsp_rdata=0, rsp_valid=1.
//    - Read: next state is RDWAIT.
//    - Strobes drop to 0 on leaving ISSUE.
//  - RDWAIT (1 cycle):
//    - The bank's readData is now valid; sample it into rsp_rdata.
//    - Set rsp_write=0, rsp_valid=1; go to RESP.
//  - RESP:
//    - Hold rsp_valid, rsp_write and rsp_rdata stable until rsp_ready=1.
//    - On handshake, clear rsp_valid and return to IDLE.
//  - address and writeData hold their last value outside ISSUE. Never are both
//    strobes high; never more than one strobe cycle per command.
//  - Latency, accept edge to rsp_valid high: write 2 cycles, read 3 cycles.
//    With rsp_ready tied 1, throughput is 1 write per 3 cycles, 1 read per 4 cycles.
//  - A new command is never accepted while a response is pending: cmd_ready=0
//    in ISSUE, RDWAIT and RESP. There is no overlap or reordering.
//  - Address and data are passed through at full width with no truncation.
//    Address decoding and unmapped-address handling belong to the register bank.
// TESTING
//  1 Reset: hold rstn=0, drive random inputs -> all outputs at reset values,
//    cmd_ready=1. Release -> no strobe until cmd_valid.
//  2 Write: cmd write addr=0x04 data=0xA5 -> next cycle address=0x04,
//    writeData=0xA5, writeEnable=1 for exactly 1 cycle. Then rsp_valid=1,
//    rsp_write=1, rsp_rdata=0.
//  3 Read-back: after test 2, cmd read addr=0x04 -> readEnable pulse of 1 cycle.
//    rsp_valid 3 cycles after accept, rsp_rdata=0xA5, rsp_write=0.
//  4 Backpressure: rsp_ready=0 for 10 cycles after a read response ->
//    rsp_valid/rsp_rdata stable, cmd_ready=0. A held cmd_valid is not accepted
//    until 1 cycle after the rsp handshake.
//  5 Back-to-back: 4 writes then 4 reads to addrs 0..3 with rsp_ready=1 ->
//    responses in order, read data matches written data, no strobe overlap.
//  6 Reset mid-read: assert rstn=0 during RDWAIT -> rsp_valid never rises.
//    After release, cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/regmap0_bus_master.sv
// regmap0_bus_master: valid/ready command-to-register-bank initiator.
// Each command gets one strobe cycle, and its response is held until the host consumes it.
module regmap0_bus_master #(
   parameter int width        = 8,
   parameter int addressWidth = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [addressWidth-1:0] cmd_addr,
   input  logic [width-1:0]        cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [width-1:0]        rsp_rdata,
   output logic [addressWidth-1:0] address,
   output logic                    writeEnable,
   output logic [width-1:0]        writeData,
   output logic                    readEnable,
   input  logic [width-1:0]        readData
);
   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;
   state_t                  state_q, state_d;
   logic [addressWidth-1:0] address_q, address_d;
   logic [width-1:0]        wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic                    re_q, re_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_write_q, rsp_write_d;
   logic [width-1:0]        rsp_rdata_q, rsp_rdata_d;
   always_comb begin
      state_d     = state_q;
      address_d   = address_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            address_d = cmd_addr;
            wdata_d   = cmd_wdata;
            we_d      = cmd_write;
            re_d      = !cmd_write;
            state_d   = ISSUE;
         end
         // The write strobe still marks the command type while in ISSUE
         ISSUE: if (we_q) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
         end else state_d = RDWAIT;
         RDWAIT: begin
            rsp_rdata_d = readData;
            rsp_write_d = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         address_q   <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         address_q   <= address_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         re_q        <= re_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end
   assign cmd_ready   = (state_q == IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_write   = rsp_write_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign address     = address_q;
   assign writeEnable = we_q;
   assign writeData   = wdata_q;
   assign readEnable  = re_q;
endmodule

// File: tb/tb_regmap0_bus_master.sv
// tb_regmap0_bus_master: directed vector table plus hand sequences for backpressure and reset.
// A behavioural register bank answers reads one cycle after readEnable.
module tb_regmap0_bus_master;
   logic       clk = 1'b0;
   logic       rstn;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_ready, rsp_write;
   logic [7:0] rsp_rdata, address, writeData, readData;
   logic       writeEnable, readEnable;
   logic [7:0] mem [256];
   int         vectors = 0;
   int         miscompares = 0;

   regmap0_bus_master #(.width(8), .addressWidth(8)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata),
      .address(address), .writeEnable(writeEnable), .writeData(writeData),
      .readEnable(readEnable), .readData(readData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (writeEnable) mem[address] <= writeData;
      if (readEnable) readData <= mem[address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " cmd_ready"}, cmd_ready, 1);
      check({tag, " rsp_valid"}, rsp_valid, 0);
      check({tag, " strobes"}, {writeEnable, readEnable}, 0);
   endtask

   // One full transaction: accept, strobe, latency, response, optional backpressure.
   task automatic run_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input int hold);
      int t = 0;
      int c = 1;
      int strobes;
      logic overlap;
      @(negedge clk);
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      check("cmd_ready wait", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 0;
      check("issue cmd_ready", cmd_ready, 0);
      check("issue strobe", {writeEnable, readEnable}, w ? 2'b10 : 2'b01);
      check("issue address", address, a);
      if (w) check("issue writeData", writeData, d);
      strobes = writeEnable + readEnable;
      overlap = writeEnable & readEnable;
      while (!rsp_valid && c < 20) begin
         @(negedge clk); c++;
         strobes += writeEnable + readEnable;
         overlap |= writeEnable & readEnable;
      end
      check("latency", c, w ? 2 : 3);
      check("strobe count", strobes, 1);
      check("strobe overlap", overlap, 0);
      check("rsp_write", rsp_write, w);
      check("rsp_rdata", rsp_rdata, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold rsp_valid", rsp_valid, 1);
         check("hold rsp_rdata", rsp_rdata, exp);
         check("hold cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check_idle_outputs("post-handshake");
   endtask

   typedef struct {
      logic       w;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
      int         hold;
   } vec_t;

   vec_t vt [15];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      vt[0]  = '{1'b1, 8'h04, 8'hA5, 8'h00, 0};
      vt[1]  = '{1'b0, 8'h04, 8'h00, 8'hA5, 0};
      vt[2]  = '{1'b0, 8'h04, 8'h33, 8'hA5, 10};
      vt[3]  = '{1'b1, 8'h00, 8'h11, 8'h00, 0};
      vt[4]  = '{1'b1, 8'h01, 8'h22, 8'h00, 0};
      vt[5]  = '{1'b1, 8'h02, 8'h33, 8'h00, 0};
      vt[6]  = '{1'b1, 8'h03, 8'h44, 8'h00, 0};
      vt[7]  = '{1'b0, 8'h00, 8'hFF, 8'h11, 0};
      vt[8]  = '{1'b0, 8'h01, 8'h00, 8'h22, 0};
      vt[9]  = '{1'b0, 8'h02, 8'h00, 8'h33, 0};
      vt[10] = '{1'b0, 8'h03, 8'h00, 8'h44, 0};
      vt[11] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 2};
      vt[12] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 0};
      vt[13] = '{1'b1, 8'h80, 8'h5C, 8'h00, 0};
      vt[14] = '{1'b0, 8'h80, 8'h00, 8'h5C, 0};

      rstn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
         cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom); rsp_ready = 1'($urandom);
         #1;
         check_idle_outputs("reset");
         check("reset address", address, 0);
         check("reset writeData", writeData, 0);
         check("reset rsp_write", rsp_write, 0);
         check("reset rsp_rdata", rsp_rdata, 0);
      end
      @(negedge clk);
      cmd_valid = 0; rsp_ready = 0;
      rstn = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outputs("released idle");
      end

      for (int i = 0; i < 15; i++) run_cmd(vt[i].w, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].hold);

      // Held command while a read response is backpressured
      @(negedge clk);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h04; rsp_ready = 0;
      @(negedge clk);
      cmd_write = 1; cmd_addr = 8'h10; cmd_wdata = 8'h5A;
      @(negedge clk);
      @(negedge clk);
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_rdata", rsp_rdata, 8'hA5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp hold valid", rsp_valid, 1);
         check("bp hold rdata", rsp_rdata, 8'hA5);
         check("bp hold cmd_ready", cmd_ready, 0);
         check("bp hold strobes", {writeEnable, readEnable}, 0);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check_idle_outputs("bp handshake");
      @(negedge clk);
      cmd_valid = 0;
      check("bp accepted strobe", {writeEnable, readEnable}, 2'b10);
      check("bp accepted address", address, 8'h10);
      check("bp accepted wdata", writeData, 8'h5A);
      @(negedge clk);
      check("bp ack valid", rsp_valid, 1);
      check("bp ack write", rsp_write, 1);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check_idle_outputs("bp ack done");

      // Reset during RDWAIT discards the read
      @(negedge clk);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h04;
      @(negedge clk);
      cmd_valid = 0;
      check("rst-mid readEnable", readEnable, 1);
      @(negedge clk);
      rstn = 0;
      #1;
      check_idle_outputs("rst-mid");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst-mid rsp_valid", rsp_valid, 0);
      end
      rstn = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outputs("rst-mid released");
      end
      run_cmd(1'b0, 8'h04, 8'h00, 8'hA5, 0);
      run_cmd(1'b0, 8'h10, 8'h00, 8'h5A, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
